seq_step_ctrl: RTL and testbench

SEQ_STEP_CTRL -- requirements
Module: seq_step_ctrl

---
 rtl/seq_step_ctrl.sv | 135 +++++++++++++
 tb/tb_seq_step_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_step_ctrl.sv
// Step-sequence controller: replays a 4-entry step table for a latched number of passes,
// with hold/stop control. The pass-count input is repeat_cnt since "repeat" is a keyword.
module seq_step_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic [3:0] repeat_cnt,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [2:0] cfg_data,
  output logic [2:0] count,
  output logic       step_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] tbl_q [4];
  logic [1:0] idx_q, idx_d, idx_nxt;
  logic [3:0] pass_q, pass_d;
  logic [3:0] rep_q, rep_d;
  logic [2:0] count_q, count_d;
  logic       sv_q, sv_d;
  logic       active, advance, last_step;

  assign active    = (state_q == StRun) || (state_q == StHold);
  assign advance   = active && !stop && !hold;
  assign idx_nxt   = idx_q + 2'd1;
  // Completion is judged on the step leaving idx 3; repeat of 0 never completes.
  assign last_step = (idx_q == 2'd3) && (rep_q != 4'd0) && ((pass_q + 4'd1) == rep_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      pass_q  <= 4'd0;
      rep_q   <= 4'd0;
      count_q <= 3'd0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      rep_q   <= rep_d;
      count_q <= count_d;
      sv_q    <= sv_d;
    end
  end

  // Table is writable only while idle so a run always sees a stable table.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_q[0] <= 3'd0;
      tbl_q[1] <= 3'd2;
      tbl_q[2] <= 3'd3;
      tbl_q[3] <= 3'd7;
    end else if (cfg_we && (state_q == StIdle)) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StRun;
      end
      StRun, StHold: begin
        if (stop) begin
          state_d = StIdle;
        end else if (hold) begin
          state_d = StHold;
        end else if (last_step) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    pass_d  = pass_q;
    rep_d   = rep_q;
    count_d = count_q;
    sv_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        count_d = 3'd0;
        if (start && !stop) begin
          idx_d   = 2'd0;
          pass_d  = 4'd0;
          rep_d   = repeat_cnt;
          count_d = tbl_q[0];
          sv_d    = 1'b1;
        end
      end
      StRun, StHold: begin
        if (stop || (advance && last_step)) begin
          idx_d   = 2'd0;
          pass_d  = 4'd0;
          count_d = 3'd0;
        end else if (advance) begin
          idx_d   = idx_nxt;
          count_d = tbl_q[idx_nxt];
          sv_d    = 1'b1;
          if (idx_q == 2'd3) pass_d = pass_q + 4'd1;
        end
      end
      StDone: begin
        idx_d   = 2'd0;
        pass_d  = 4'd0;
        count_d = 3'd0;
      end
      default: begin
        count_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    count      = count_q;
    step_valid = sv_q;
    busy       = active;
    done       = (state_q == StDone);
  end

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed bench for seq_step_ctrl: a vector table of per-cycle inputs and expected outputs,
// plus hand-written reset-mid-run and hold sequences.
module tb_seq_step_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, hold, cfg_we;
  logic [3:0] repeat_cnt;
  logic [1:0] cfg_addr;
  logic [2:0] cfg_data;
  logic [2:0] count;
  logic       step_valid, busy, done;

  always #5 clk = ~clk;

  seq_step_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .repeat_cnt (repeat_cnt),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .count      (count),
    .step_valid (step_valid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string      name;
    logic       r, st, sp, h;
    logic [3:0] rp;
    logic       we;
    logic [1:0] a;
    logic [2:0] d;
    logic [5:0] exp;  // {count, step_valid, busy, done} after the edge
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   steps    = 0;

  function automatic void add(string name, logic r, logic st, logic sp, logic h,
                              logic [3:0] rp, logic we, logic [1:0] a, logic [2:0] d,
                              logic [2:0] ec, logic esv, logic eb, logic ed);
    vec_t v;
    v.name = name; v.r = r; v.st = st; v.sp = sp; v.h = h; v.rp = rp;
    v.we = we; v.a = a; v.d = d; v.exp = {ec, esv, eb, ed};
    vecs.push_back(v);
  endfunction

  function automatic void nop(string name, logic [2:0] ec, logic esv, logic eb, logic ed);
    add(name, 0, 0, 0, 0, 4'd0, 0, 2'd0, 3'd0, ec, esv, eb, ed);
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {count, step_valid, busy, done};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got count=%0d sv=%b busy=%b done=%b, want count=%0d sv=%b busy=%b done=%b",
                  name, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic drive(input logic r, input logic st, input logic sp, input logic h,
                       input logic [3:0] rp);
    @(negedge clk);
    rst = r; start = st; stop = sp; hold = h; repeat_cnt = rp;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 3'd0;
    @(posedge clk);
    #1;
    if (step_valid) steps++;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.r; start = v.st; stop = v.sp; hold = v.h; repeat_cnt = v.rp;
    cfg_we = v.we; cfg_addr = v.a; cfg_data = v.d;
    @(posedge clk);
    #1;
    check(v.name, v.exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; repeat_cnt = 4'd0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 3'd0;

    // Reset, then a single pass with the default table.
    add("reset0", 1, 0, 0, 0, 4'd0, 0, 2'd0, 3'd0, 3'd0, 0, 0, 0);
    add("reset1", 1, 1, 0, 0, 4'd1, 0, 2'd0, 3'd0, 3'd0, 0, 0, 0);
    nop("idle", 3'd0, 0, 0, 0);
    add("r1_s0", 0, 1, 0, 0, 4'd1, 0, 2'd0, 3'd0, 3'd0, 1, 1, 0);
    nop("r1_s1", 3'd2, 1, 1, 0);
    nop("r1_s2", 3'd3, 1, 1, 0);
    nop("r1_s3", 3'd7, 1, 1, 0);
    nop("r1_done", 3'd0, 0, 0, 1);
    nop("r1_idle", 3'd0, 0, 0, 0);
    // Endless run, stopped after 10 steps.
    add("r0_s0", 0, 1, 0, 0, 4'd0, 0, 2'd0, 3'd0, 3'd0, 1, 1, 0);
    nop("r0_s1", 3'd2, 1, 1, 0);
    nop("r0_s2", 3'd3, 1, 1, 0);
    nop("r0_s3", 3'd7, 1, 1, 0);
    nop("r0_s4", 3'd0, 1, 1, 0);
    nop("r0_s5", 3'd2, 1, 1, 0);
    nop("r0_s6", 3'd3, 1, 1, 0);
    nop("r0_s7", 3'd7, 1, 1, 0);
    nop("r0_s8", 3'd0, 1, 1, 0);
    nop("r0_s9", 3'd2, 1, 1, 0);
    add("r0_stop", 0, 0, 1, 0, 4'd0, 0, 2'd0, 3'd0, 3'd0, 0, 0, 0);
    nop("r0_idle", 3'd0, 0, 0, 0);
    // start and stop together from idle.
    add("st_sp", 0, 1, 1, 0, 4'd1, 0, 2'd0, 3'd0, 3'd0, 0, 0, 0);
    nop("st_sp_idle", 3'd0, 0, 0, 0);
    // Reprogram table, two passes; cfg write and start during the run are ignored.
    add("cfg0", 0, 0, 0, 0, 4'd0, 1, 2'd0, 3'd1, 3'd0, 0, 0, 0);
    add("cfg1", 0, 0, 0, 0, 4'd0, 1, 2'd1, 3'd4, 3'd0, 0, 0, 0);
    add("cfg2", 0, 0, 0, 0, 4'd0, 1, 2'd2, 3'd5, 3'd0, 0, 0, 0);
    add("cfg3", 0, 0, 0, 0, 4'd0, 1, 2'd3, 3'd6, 3'd0, 0, 0, 0);
    add("r2_s0", 0, 1, 0, 0, 4'd2, 0, 2'd0, 3'd0, 3'd1, 1, 1, 0);
    nop("r2_s1", 3'd4, 1, 1, 0);
    add("r2_s2_cfg", 0, 0, 0, 0, 4'd0, 1, 2'd0, 3'd7, 3'd5, 1, 1, 0);
    add("r2_s3_start", 0, 1, 0, 0, 4'd1, 0, 2'd0, 3'd0, 3'd6, 1, 1, 0);
    nop("r2_s4", 3'd1, 1, 1, 0);
    nop("r2_s5", 3'd4, 1, 1, 0);
    nop("r2_s6", 3'd5, 1, 1, 0);
    nop("r2_s7", 3'd6, 1, 1, 0);
    nop("r2_done", 3'd0, 0, 0, 1);
    nop("r2_idle", 3'd0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset at the third step: outputs clear, no done, table back to defaults.
    drive(0, 1, 0, 0, 4'd0); check("mr_s0", {3'd1, 3'b110});
    drive(0, 0, 0, 0, 4'd0); check("mr_s1", {3'd4, 3'b110});
    drive(0, 0, 0, 0, 4'd0); check("mr_s2", {3'd5, 3'b110});
    drive(1, 0, 0, 0, 4'd0); check("mr_rst", {3'd0, 3'b000});
    drive(0, 0, 0, 0, 4'd0); check("mr_nodone", {3'd0, 3'b000});
    drive(0, 1, 0, 0, 4'd1); check("mr_tbl0", {3'd0, 3'b110});
    drive(0, 0, 0, 0, 4'd0); check("mr_tbl1", {3'd2, 3'b110});
    drive(0, 0, 0, 0, 4'd0); check("mr_tbl2", {3'd3, 3'b110});
    drive(0, 0, 0, 0, 4'd0); check("mr_tbl3", {3'd7, 3'b110});
    drive(0, 0, 0, 0, 4'd0); check("mr_done", {3'd0, 3'b001});

    // Hold three cycles at count=3, then resume; exactly 4 steps in the run.
    drive(1, 0, 0, 0, 4'd0); check("hd_rst", {3'd0, 3'b000});
    steps = 0;
    drive(0, 1, 0, 0, 4'd1); check("hd_s0", {3'd0, 3'b110});
    drive(0, 0, 0, 0, 4'd0); check("hd_s1", {3'd2, 3'b110});
    drive(0, 0, 0, 0, 4'd0); check("hd_s2", {3'd3, 3'b110});
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 4'd0); check("hd_frozen", {3'd3, 3'b010});
    end
    drive(0, 0, 0, 0, 4'd0); check("hd_resume", {3'd7, 3'b110});
    for (int i = 0; i < 8 && !done; i++) drive(0, 0, 0, 0, 4'd0);
    check("hd_done", {3'd0, 3'b001});
    n_checks++;
    if (steps == 4) n_pass++;
    else $display("FAIL hd_steps: got %0d steps, want 4", steps);
    drive(0, 0, 0, 0, 4'd0); check("hd_idle", {3'd0, 3'b000});

    // stop beats hold.
    drive(0, 1, 0, 0, 4'd0); check("sh_s0", {3'd0, 3'b110});
    drive(0, 0, 1, 1, 4'd0); check("sh_stop", {3'd0, 3'b000});
    drive(0, 0, 0, 0, 4'd0); check("sh_idle", {3'd0, 3'b000});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
